// File: rtl/pe_grid_pkg.sv
// pe_grid_pkg: shared state encoding and default widths for the PE grid sequencer
`timescale 1ns/1ps
package pe_grid_pkg;
  localparam int CFG_W  = 8;
  localparam int CNT_W  = 16;
  localparam int PERF_W = 32;
  typedef enum logic [2:0] {IDLE, LOAD_W, LOAD_I, COMPUTE, DRAIN, DONE} seq_state_e;
endpackage

// File: rtl/seq_beat_cnt.sv
// seq_beat_cnt: clearable beat counter flagging the beat that reaches last_i
`timescale 1ns/1ps
module seq_beat_cnt import pe_grid_pkg::*; #(
  parameter int W = CNT_W
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         clr_i,
  input  logic         inc_i,
  input  logic [W-1:0] last_i,
  output logic         tc_o
);
  logic [W-1:0] cnt_q;
  assign tc_o = inc_i && (cnt_q == last_i);
  // clear wins over increment so a phase change always restarts at zero
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) cnt_q <= '0;
    else cnt_q <= clr_i ? '0 : inc_i ? cnt_q + W'(1) : cnt_q;
endmodule

// File: rtl/pe_grid_sequencer.sv
// pe_grid_sequencer: per-pass weight/iact load, compute and drain sequencing for a PE grid; SEQ_PERF_CNT_EN adds cycle_count
`timescale 1ns/1ps
module pe_grid_sequencer import pe_grid_pkg::*; #(
  parameter int MAX_CONFIG_WIDTH = CFG_W,
  parameter int CNT_WIDTH        = CNT_W
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        start,
  input  logic [MAX_CONFIG_WIDTH-1:0] filter_size,
  input  logic [MAX_CONFIG_WIDTH-1:0] ifmap_width,
  input  logic [MAX_CONFIG_WIDTH-1:0] output_channels_num,
  input  logic                        weight_buffer_ready,
  input  logic                        iact_buffer_ready,
  input  logic                        psum_out_valid,
  output logic                        weight_write_en,
  output logic                        iact_write_en,
  output logic                        psum_read_en,
  output logic                        grid_en,
  output logic                        busy,
  output logic                        done,
  output logic                        cfg_error,
  output logic [MAX_CONFIG_WIDTH-1:0] pass_idx
`ifdef SEQ_PERF_CNT_EN
  ,output logic [PERF_W-1:0]          cycle_count
`endif
);
  localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);
  seq_state_e state_q, state_d;
  logic [MAX_CONFIG_WIDTH-1:0] fs_q, iw_q, oc_q, pass_idx_q;
  logic cfg_error_q, cfg_ok, accept, more, inc, tc;
  logic [CNT_WIDTH-1:0] ow, comp_len, target;
  assign cfg_ok   = (filter_size != '0) && (output_channels_num != '0) && (ifmap_width >= filter_size);
  assign accept   = (state_q == IDLE) && start && cfg_ok;
  assign ow       = CNT_WIDTH'(iw_q) - CNT_WIDTH'(fs_q) + ONE;
  assign comp_len = CNT_WIDTH'(fs_q) * ow;
  assign more     = ({1'b0, pass_idx_q} + (MAX_CONFIG_WIDTH+1)'(1)) < {1'b0, oc_q};
  assign target   = (state_q == LOAD_W) ? CNT_WIDTH'(fs_q) :
                    (state_q == LOAD_I) ? CNT_WIDTH'(iw_q) :
                    (state_q == COMPUTE) ? comp_len : ow;
  assign weight_write_en = (state_q == LOAD_W) && weight_buffer_ready;
  assign iact_write_en   = (state_q == LOAD_I) && iact_buffer_ready;
  assign psum_read_en    = (state_q == DRAIN);
  assign busy            = (state_q != IDLE);
  assign grid_en         = busy;
  assign done            = (state_q == DONE);
  assign cfg_error       = cfg_error_q;
  assign pass_idx        = pass_idx_q;
  assign inc = weight_write_en || iact_write_en || (state_q == COMPUTE) || (psum_read_en && psum_out_valid);
  seq_beat_cnt #(.W(CNT_WIDTH)) u_cnt (
    .clk    (clk),
    .rstn   (rstn),
    .clr_i  (state_d != state_q),
    .inc_i  (inc),
    .last_i (target - ONE),
    .tc_o   (tc)
  );
  // phase sequencing: each phase ends on its terminal beat
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = accept ? LOAD_W : IDLE;
      LOAD_W:  state_d = tc ? LOAD_I : LOAD_W;
      LOAD_I:  state_d = tc ? COMPUTE : LOAD_I;
      COMPUTE: state_d = tc ? DRAIN : COMPUTE;
      DRAIN:   state_d = tc ? (more ? LOAD_W : DONE) : DRAIN;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // state, latched job config, pass index and config-error pulse
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      state_q     <= IDLE;
      fs_q        <= '0;
      iw_q        <= '0;
      oc_q        <= '0;
      pass_idx_q  <= '0;
      cfg_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cfg_error_q <= (state_q == IDLE) && start && !cfg_ok;
      if (accept) begin
        fs_q       <= filter_size;
        iw_q       <= ifmap_width;
        oc_q       <= output_channels_num;
        pass_idx_q <= '0;
      end else if (psum_read_en && tc && more) pass_idx_q <= pass_idx_q + MAX_CONFIG_WIDTH'(1);
    end
`ifdef SEQ_PERF_CNT_EN
  logic [PERF_W-1:0] cyc_q;
  assign cycle_count = cyc_q;
  // busy-cycle counter, restarted by each accepted job and saturating at all-ones
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) cyc_q <= '0;
    else if (accept) cyc_q <= '0;
    else if (busy && cyc_q != '1) cyc_q <= cyc_q + PERF_W'(1);
`endif
endmodule
